// File: rtl/reg_bank.sv
// Register bank with DEPTH x WIDTH entries, per-entry valid bits, two registered
// read ports with write-first forwarding, and a one-entry-per-cycle clear engine.
module reg_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic             ra_valid,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_valid,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  typedef enum logic {IDLE, CLEARING} state_e;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en, clr_en;
  logic [WIDTH-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;
  logic             ra_valid_q, ra_valid_d, rb_valid_q, rb_valid_d;

  // A clear request in IDLE takes priority and suppresses any same-edge write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEARING;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          wr_en = we && ({1'b0, waddr} < DEPTH_L) && !(ZERO_REG && (waddr == '0));
        end
      end
      CLEARING: begin
        clr_en = 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ra_data_d  = '0;
    ra_valid_d = 1'b0;
    if (wr_en && (waddr == ra_addr)) begin
      ra_data_d  = wdata;
      ra_valid_d = 1'b1;
    end else if (ZERO_REG && (ra_addr == '0)) begin
      ra_valid_d = 1'b1;
    end else if ({1'b0, ra_addr} < DEPTH_L) begin
      ra_data_d  = mem_q[ra_addr];
      ra_valid_d = valid_q[ra_addr];
    end
  end

  always_comb begin
    rb_data_d  = '0;
    rb_valid_d = 1'b0;
    if (wr_en && (waddr == rb_addr)) begin
      rb_data_d  = wdata;
      rb_valid_d = 1'b1;
    end else if (ZERO_REG && (rb_addr == '0)) begin
      rb_valid_d = 1'b1;
    end else if ({1'b0, rb_addr} < DEPTH_L) begin
      rb_data_d  = mem_q[rb_addr];
      rb_valid_d = valid_q[rb_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= '0;
      ra_data_q  <= '0;
      ra_valid_q <= 1'b0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ra_data_q  <= ra_data_d;
      ra_valid_q <= ra_valid_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      if (wr_en) begin
        mem_q[waddr]   <= wdata;
        valid_q[waddr] <= 1'b1;
      end
      if (clr_en) begin
        mem_q[cnt_q]   <= '0;
        valid_q[cnt_q] <= 1'b0;
      end
    end
  end

  assign ra_data  = ra_data_q;
  assign ra_valid = ra_valid_q;
  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
  assign busy     = busy_q;
  assign clr_done = done_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default build plus a DEPTH=6, ZERO_REG=1 build.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we, clr_req, ra_valid, rb_valid, busy, clr_done;
  logic [2:0]  waddr, ra_addr, rb_addr;
  logic [15:0] wdata, ra_data, rb_data;

  logic        z_we, z_clr_req, z_ra_valid, z_rb_valid, z_busy, z_clr_done;
  logic [2:0]  z_waddr, z_ra_addr, z_rb_addr;
  logic [15:0] z_wdata, z_ra_data, z_rb_data;

  reg_bank #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .ra_data(ra_data), .ra_valid(ra_valid),
    .rb_addr(rb_addr), .rb_data(rb_data), .rb_valid(rb_valid),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  reg_bank #(.WIDTH(16), .DEPTH(6), .AW(3), .ZERO_REG(1'b1)) u_zdut (
    .clk(clk), .rst_n(rst_n), .we(z_we), .waddr(z_waddr), .wdata(z_wdata),
    .ra_addr(z_ra_addr), .ra_data(z_ra_data), .ra_valid(z_ra_valid),
    .rb_addr(z_rb_addr), .rb_data(z_rb_data), .rb_valid(z_rb_valid),
    .clr_req(z_clr_req), .busy(z_busy), .clr_done(z_clr_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!clr_done && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, clr_done}, 32'd1);
  endtask

  typedef struct {
    bit          z;
    bit          we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ead;
    bit          eav;
    logic [15:0] ebd;
    bit          ebv;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [15:0] ad, bd;
    logic        av, bv;
    int          busy_cycles;
    int          k;

    tbl[0] = '{1'b0, 1'b1, 3'd3, 16'd12345, 3'd3, 3'd5, 16'd12345, 1'b1, 16'd0,     1'b0};
    tbl[1] = '{1'b0, 1'b1, 3'd5, 16'h8285,  3'd3, 3'd5, 16'd12345, 1'b1, 16'h8285,  1'b1};
    tbl[2] = '{1'b0, 1'b0, 3'd0, 16'd0,     3'd3, 3'd5, 16'd12345, 1'b1, 16'h8285,  1'b1};
    tbl[3] = '{1'b0, 1'b0, 3'd0, 16'd0,     3'd2, 3'd2, 16'd0,     1'b0, 16'd0,     1'b0};
    tbl[4] = '{1'b0, 1'b1, 3'd4, 16'd11111, 3'd4, 3'd4, 16'd11111, 1'b1, 16'd11111, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 16'd0,     3'd4, 3'd3, 16'd11111, 1'b1, 16'd12345, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 3'd0, 16'hFFFF,  3'd0, 3'd0, 16'd0,     1'b1, 16'd0,     1'b1};
    tbl[7] = '{1'b1, 1'b1, 3'd7, 16'h1234,  3'd7, 3'd7, 16'd0,     1'b0, 16'd0,     1'b0};
    tbl[8] = '{1'b1, 1'b0, 3'd0, 16'd0,     3'd0, 3'd7, 16'd0,     1'b1, 16'd0,     1'b0};
    tbl[9] = '{1'b1, 1'b1, 3'd5, 16'h8285,  3'd5, 3'd6, 16'h8285,  1'b1, 16'd0,     1'b0};

    we = 0; waddr = 0; wdata = 0; ra_addr = 0; rb_addr = 0; clr_req = 0;
    z_we = 0; z_waddr = 0; z_wdata = 0; z_ra_addr = 0; z_rb_addr = 0; z_clr_req = 0;

    #12;
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
    chk("rst_ra_data",  {16'd0, ra_data},  32'd0);
    chk("rst_ra_valid", {31'd0, ra_valid}, 32'd0);
    chk("rst_rb_valid", {31'd0, rb_valid}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      we = 0; z_we = 0;
      if (tbl[i].z) begin
        z_we = tbl[i].we; z_waddr = tbl[i].wa; z_wdata = tbl[i].wd;
        z_ra_addr = tbl[i].ra; z_rb_addr = tbl[i].rb;
      end else begin
        we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
        ra_addr = tbl[i].ra; rb_addr = tbl[i].rb;
      end
      tick();
      ad = tbl[i].z ? z_ra_data  : ra_data;
      av = tbl[i].z ? z_ra_valid : ra_valid;
      bd = tbl[i].z ? z_rb_data  : rb_data;
      bv = tbl[i].z ? z_rb_valid : rb_valid;
      chk($sformatf("vec%0d_ra_data", i),  {16'd0, ad}, {16'd0, tbl[i].ead});
      chk($sformatf("vec%0d_ra_valid", i), {31'd0, av}, {31'd0, tbl[i].eav});
      chk($sformatf("vec%0d_rb_data", i),  {16'd0, bd}, {16'd0, tbl[i].ebd});
      chk($sformatf("vec%0d_rb_valid", i), {31'd0, bv}, {31'd0, tbl[i].ebv});
    end
    we = 0; z_we = 0;

    // Fill, then clear with a dropped write and an ignored second request mid-sequence.
    for (int i = 0; i < 8; i++) begin
      we = 1; waddr = 3'(i); wdata = 16'(16'h1000 + i);
      tick();
    end
    we = 0; ra_addr = 3'd7; rb_addr = 3'd0; clr_req = 1;
    tick();
    chk("clr_start_busy", {31'd0, busy},     32'd1);
    chk("clr_start_done", {31'd0, clr_done}, 32'd0);
    busy_cycles = 1;
    for (k = 1; k <= 20; k++) begin
      we = (k == 2); waddr = 3'd2; wdata = 16'hFFFF;
      clr_req = (k == 3);
      tick();
      if (k == 4) begin
        chk("mid_clr_ra_data",  {16'd0, ra_data},  32'h1007);
        chk("mid_clr_ra_valid", {31'd0, ra_valid}, 32'd1);
        chk("mid_clr_rb_data",  {16'd0, rb_data},  32'd0);
        chk("mid_clr_rb_valid", {31'd0, rb_valid}, 32'd0);
      end
      if (!busy) break;
      busy_cycles++;
    end
    we = 0; clr_req = 0;
    chk("busy_cycles", busy_cycles, 32'd8);
    chk("clr_done_pulse", {31'd0, clr_done}, 32'd1);
    tick();
    chk("clr_done_drop", {31'd0, clr_done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); rb_addr = 3'(7 - i);
      tick();
      chk($sformatf("post_clr%0d_ra_data", i),  {16'd0, ra_data},  32'd0);
      chk($sformatf("post_clr%0d_ra_valid", i), {31'd0, ra_valid}, 32'd0);
      chk($sformatf("post_clr%0d_rb_valid", i), {31'd0, rb_valid}, 32'd0);
    end

    // Clear and write together, then a new request on the clr_done cycle.
    clr_req = 1; we = 1; waddr = 3'd1; wdata = 16'hABCD; ra_addr = 3'd1; rb_addr = 3'd1;
    tick();
    chk("conflict_ra_data",  {16'd0, ra_data},  32'd0);
    chk("conflict_ra_valid", {31'd0, ra_valid}, 32'd0);
    chk("conflict_busy",     {31'd0, busy},     32'd1);
    clr_req = 0; we = 0;
    wait_done("conflict_wait_done");
    clr_req = 1;
    tick();
    chk("restart_busy", {31'd0, busy},     32'd1);
    chk("restart_done", {31'd0, clr_done}, 32'd0);
    clr_req = 0;
    wait_done("restart_wait_done");
    tick();
    chk("conflict_addr1_data",  {16'd0, ra_data},  32'd0);
    chk("conflict_addr1_valid", {31'd0, ra_valid}, 32'd0);

    // Asynchronous reset in the middle of a clear.
    we = 1; waddr = 3'd6; wdata = 16'h6666;
    tick();
    waddr = 3'd7; wdata = 16'h7777;
    tick();
    we = 0; ra_addr = 3'd6; rb_addr = 3'd7; clr_req = 1;
    tick();
    clr_req = 0;
    tick();
    tick();
    chk("pre_rst_ra_data", {16'd0, ra_data}, 32'h6666);
    chk("pre_rst_busy",    {31'd0, busy},    32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",     {31'd0, busy},     32'd0);
    chk("arst_clr_done", {31'd0, clr_done}, 32'd0);
    chk("arst_ra_data",  {16'd0, ra_data},  32'd0);
    chk("arst_ra_valid", {31'd0, ra_valid}, 32'd0);
    chk("arst_rb_data",  {16'd0, rb_data},  32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("after_rst_ra_data",  {16'd0, ra_data},  32'd0);
    chk("after_rst_ra_valid", {31'd0, ra_valid}, 32'd0);
    chk("after_rst_rb_data",  {16'd0, rb_data},  32'd0);
    chk("after_rst_rb_valid", {31'd0, rb_valid}, 32'd0);
    chk("after_rst_busy",     {31'd0, busy},     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised successor to the single 16-bit load register: a bank of DEPTH registers, each WIDTH bits.
- One write port and two registered read ports (A, B), with write-first forwarding.
- Each entry has a valid bit.
- A sequenced clear engine zeroes the bank one entry per cycle.
- Serves as the general-purpose register storage for the CPU datapath.

Parameters:
- WIDTH, 16, data width of every entry; contents are raw bits, so signed values pass through unchanged.
- DEPTH, 8, number of entries; any value from 2 to 256.
- AW, 3, address width; must equal ceil(log2(DEPTH)).
- ZERO_REG, 0, when 1, entry 0 is hardwired to zero and always valid; writes to it are dropped.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable, sampled at the rising edge
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- ra_addr  in  AW  read port A address
- ra_data  out  WIDTH  read port A data, registered
- ra_valid  out  1  valid bit of the entry read on port A, registered
- rb_addr  in  AW  read port B address
- rb_data  out  WIDTH  read port B data, registered
- rb_valid  out  1  valid bit of the entry read on port B, registered
- clr_req  in  1  request to clear the bank, sampled at the rising edge
- busy  out  1  high while the clear sequence runs
- clr_done  out  1  one-cycle pulse when the clear sequence completes

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All entries 0 and all valid bits 0.
  - ra_data=rb_data=0, ra_valid=rb_valid=0.
  - busy=0, clr_done=0, state IDLE, clear counter 0.
  - Reset asserted mid-clear aborts the sequence and applies the same values.
- Write (state IDLE):
  - At an edge with we=1 and waddr<DEPTH: entry[waddr] <= wdata and valid[waddr] <= 1.
  - Dropped if waddr>=DEPTH.
  - Dropped if ZERO_REG=1 and waddr=0.
- Read:
  - Each port samples its address at every edge; data and valid appear after the edge, giving 1-cycle latency.
  - Write-first forwarding: if the same edge performs a write to the read address, the port returns wdata with valid=1.
  - Both ports may read the same address.
  - Address>=DEPTH returns data 0, valid 0.
  - With ZERO_REG=1, address 0 returns data 0, valid 1.
- Clear state machine, two states: IDLE and CLEARING.
  - IDLE -> CLEARING at an edge with clr_req=1; counter <= 0 and busy <= 1.
  - In CLEARING, each edge zeroes entry[counter] and valid[counter], then increments the counter.
  - The edge that clears entry DEPTH-1 moves the state to IDLE, sets busy <= 0 and sets clr_done <= 1 for exactly one cycle.
  - busy is therefore high for exactly DEPTH cycles.
- Boundary rules:
  - clr_req while CLEARING is ignored and does not restart the sequence.
  - we and clr_req together in IDLE: the clear wins and the write is dropped.
  - we during CLEARING is dropped, including the final clearing edge.
  - Reads during CLEARING proceed normally: an entry already cleared reads 0/invalid, one not yet cleared reads its old contents.
  - Forwarding never applies during CLEARING.
  - clr_done is 0 at all other times, and it may coincide with a new clr_req. In that case the next sequence starts at that edge.
  - No arithmetic is performed; no wrap-around is possible other than the clear counter, which stops at DEPTH-1.

Test Plan:
- Reset, then write 12345 to addr 3 and -32123 (0x8285) to addr 5.
  - Read A=3, B=5 on the next cycle -> ra_data=12345, rb_data=0x8285, both valid=1.
  - Read addr 2 -> data 0, valid 0.
- Forwarding: we=1, waddr=4, wdata=11111 with ra_addr=4 and rb_addr=4 in the same cycle -> after that edge, both ports show 11111, valid 1.
- Clear with DEPTH=8:
  - Fill all 8 entries, then pulse clr_req -> busy high for exactly 8 cycles, then clr_done high for 1 cycle.
  - Reading addr 7 mid-sequence (counter=3) still returns the old value.
  - After completion, all entries read 0/invalid.
- Conflicts:
  - clr_req and we to addr 1 in the same cycle -> addr 1 ends at 0/invalid.
  - we during busy is dropped.
  - A second clr_req during busy does not extend busy beyond 8 cycles.
- Asynchronous reset: assert rst_n=0 mid-clear, away from a clock edge -> busy, clr_done and all outputs drop to 0 immediately; no entry retains data.
- ZERO_REG=1 build:
  - Write 0xFFFF to addr 0 -> reads return 0, valid 1.
  - With DEPTH=6, write to addr 7 -> ignored; reading addr 7 returns 0/invalid.
